// File: rtl/alu_exec_seq.sv
// Execute/write-back controller in front of an 8 x 32-bit register bank.
// One operation per start/done handshake. The read addresses go to the bank,
// the operands are captured, the result is computed (iterative for shifts and
// multiply), and one write is driven in the WB cycle.
//
// Handshake: start is taken only in IDLE (busy=0) and is never queued.
// busy is high from the cycle after accept through the WB cycle. done pulses
// for one cycle in WB. EN pulses in the same cycle for legal opcodes, and
// illegal pulses instead of EN for unsupported opcodes.
module alu_exec_seq #(
  parameter int DW  = 32,
  parameter int AW  = 3,
  parameter int SHW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    opcode,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [AW-1:0] dest,
  input  logic [DW-1:0] REG1_DATA,
  input  logic [DW-1:0] REG2_DATA,
  output logic [AW-1:0] SRC_REG1,
  output logic [AW-1:0] SRC_REG2,
  output logic [AW-1:0] DEST_REG,
  output logic [DW-1:0] WRT_DATA,
  output logic          EN,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  logic [1:0]     state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [AW-1:0]  dest_q, dest_d;
  logic [AW-1:0]  src1_q, src1_d;
  logic [AW-1:0]  src2_q, src2_d;
  logic [AW-1:0]  dreg_q, dreg_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           en_q, en_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ill_q, ill_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic [SHW-1:0] cnt_q, cnt_d;

  logic [DW-1:0]  res;
  logic [DW-1:0]  shifted;
  logic [DW-1:0]  mul_sum;
  logic           finish;
  logic           legal;

  // One-bit-position shift of the accumulator, selected by the latched opcode.
  always_comb begin
    shifted = acc_q;
    case (op_q)
      OP_SLL:  shifted = {acc_q[DW-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, acc_q[DW-1:1]};
      OP_SRA:  shifted = {acc_q[DW-1], acc_q[DW-1:1]};
      default: shifted = acc_q;
    endcase
  end

  // Next-state logic for the FSM, the datapath, and the registered bank outputs.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dest_d  = dest_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dreg_d  = dreg_q;
    wdata_d = wdata_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res     = '0;
    finish  = 1'b0;
    legal   = 1'b1;
    mul_sum = acc_q + (b_q[0] ? a_q : '0);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          dest_d  = dest;
          src1_d  = src1;
          src2_d  = src2;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // The bank has not been written yet, so dest==src reads the old value.
        a_d = REG1_DATA;
        b_d = REG2_DATA;
        if (op_q == OP_MUL) begin
          acc_d = '0;
          cnt_d = SHW'(DW - 1);
        end else begin
          acc_d = REG1_DATA;
          cnt_d = REG2_DATA[SHW-1:0];
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:  begin res = a_q + b_q;   finish = 1'b1; end
          OP_SUB:  begin res = a_q - b_q;   finish = 1'b1; end
          OP_AND:  begin res = a_q & b_q;   finish = 1'b1; end
          OP_OR:   begin res = a_q | b_q;   finish = 1'b1; end
          OP_XOR:  begin res = a_q ^ b_q;   finish = 1'b1; end
          OP_NOR:  begin res = ~(a_q | b_q); finish = 1'b1; end
          OP_SLT:  begin res = {{(DW-1){1'b0}}, ($signed(a_q) < $signed(b_q))}; finish = 1'b1; end
          OP_SLTU: begin res = {{(DW-1){1'b0}}, (a_q < b_q)}; finish = 1'b1; end
          OP_SLL, OP_SRL, OP_SRA: begin
            // A count of 0 or 1 finishes in this cycle, so EXEC lasts max(n,1) cycles.
            if (cnt_q <= SHW'(1)) begin
              res    = (cnt_q == SHW'(1)) ? shifted : acc_q;
              finish = 1'b1;
            end else begin
              acc_d = shifted;
              cnt_d = cnt_q - SHW'(1);
            end
          end
          OP_MUL: begin
            // Shift-add, one multiplier bit per cycle. The count runs from DW-1
            // down to 0, which gives DW cycles.
            if (cnt_q == '0) begin
              res    = mul_sum;
              finish = 1'b1;
            end else begin
              acc_d = mul_sum;
              a_d   = {a_q[DW-2:0], 1'b0};
              b_d   = {1'b0, b_q[DW-1:1]};
              cnt_d = cnt_q - SHW'(1);
            end
          end
          default: begin
            legal  = 1'b0;
            finish = 1'b1;
          end
        endcase
        if (finish) begin
          state_d = S_WB;
          done_d  = 1'b1;
          if (legal) begin
            en_d    = 1'b1;
            dreg_d  = dest_q;
            wdata_d = res;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      default: begin
        // WB: the bank writes at this edge, and the next cycle is idle.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dest_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dreg_q  <= '0;
      wdata_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dreg_q  <= dreg_d;
      wdata_q <= wdata_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SRC_REG1  = src1_q;
  assign SRC_REG2  = src2_q;
  assign DEST_REG  = dreg_q;
  assign WRT_DATA  = wdata_q;
  assign EN        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign illegal   = ill_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq, which drives an 8 x 32-bit register bank model.
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic [2:0]  src1, src2, dest;
  logic [31:0] REG1_DATA, REG2_DATA;
  logic [2:0]  SRC_REG1, SRC_REG2, DEST_REG;
  logic [31:0] WRT_DATA;
  logic        EN, busy, done, illegal;
  logic [1:0]  dbg_state;

  logic [31:0] bank [8];
  logic        tb_we = 1'b0;
  logic [2:0]  tb_wa = '0;
  logic [31:0] tb_wd = '0;
  int          en_count = 0;
  int          total = 0;
  int          bad = 0;

  // Clock and reset block.
  always #5 clk = ~clk;

  alu_exec_seq #(.DW(32), .AW(3), .SHW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .src1(src1), .src2(src2), .dest(dest),
    .REG1_DATA(REG1_DATA), .REG2_DATA(REG2_DATA),
    .SRC_REG1(SRC_REG1), .SRC_REG2(SRC_REG2), .DEST_REG(DEST_REG),
    .WRT_DATA(WRT_DATA), .EN(EN), .busy(busy), .done(done),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  // Register bank model: combinational reads and a write at the clock edge.
  assign REG1_DATA = bank[SRC_REG1];
  assign REG2_DATA = bank[SRC_REG2];

  always @(posedge clk) begin
    if (tb_we) bank[tb_wa] <= tb_wd;
    else if (EN === 1'b1) bank[DEST_REG] <= WRT_DATA;
    if (EN === 1'b1) en_count <= en_count + 1;
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_reg(input logic [2:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
    opcode = op; src1 = s1; src2 = s2; dest = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts cycles from accept; the first cycle after the accept edge is 1.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d, output int cyc);
    issue(op, s1, s2, d);
    wait_done(cyc);
  endtask

  task automatic test_reset();
    logic [44:0] obs;
    rst = 1'b0; start = 1'b0; opcode = '0; src1 = '0; src2 = '0; dest = '0;
    repeat (3) step();
    obs = {SRC_REG1, SRC_REG2, DEST_REG, WRT_DATA, EN, busy, done, illegal};
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      obs = {SRC_REG1, SRC_REG2, DEST_REG, WRT_DATA, EN, busy, done, illegal};
      total++; if (obs !== '0 || dbg_state !== 2'd0) begin
        bad++; $display("FAIL idle_outputs: cycle %0d got %h state %0d expected 0", i, obs, dbg_state);
      end
    end
    total++; if (en_count !== 0) begin bad++; $display("FAIL idle_no_en: en_count %0d expected 0", en_count); end
  endtask

  task automatic test_add();
    int cyc;
    set_reg(3'd1, 32'd7);
    set_reg(3'd2, 32'd5);
    issue(4'd0, 3'd1, 3'd2, 3'd3);
    total++; if (SRC_REG1 !== 3'd1 || SRC_REG2 !== 3'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL add_addr: src1 %0d src2 %0d busy %b expected 1 2 1", SRC_REG1, SRC_REG2, busy);
    end
    wait_done(cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL add_latency: %0d expected 3", cyc); end
    total++; if (EN !== 1'b1 || DEST_REG !== 3'd3 || WRT_DATA !== 32'd12 || illegal !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL add_wb: en %b dest %0d data %h ill %b busy %b expected 1 3 0000000c 0 1", EN, DEST_REG, WRT_DATA, illegal, busy);
    end
    step();
    total++; if (EN !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || WRT_DATA !== 32'd12 || DEST_REG !== 3'd3) begin
      bad++; $display("FAIL add_after: en %b busy %b done %b data %h dest %0d expected 0 0 0 0000000c 3", EN, busy, done, WRT_DATA, DEST_REG);
    end
    total++; if (bank[3] !== 32'd12) begin bad++; $display("FAIL add_bank: R3 %h expected 0000000c", bank[3]); end
  endtask

  task automatic test_arith();
    logic [3:0]  op_t  [9] = '{4'd1, 4'd6, 4'd7, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd6};
    logic [31:0] a_t   [9] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F000FF, 32'hF0F000FF,
                               32'hF0F000FF, 32'hF0F000FF, 32'hFFFFFFFF, 32'h1};
    logic [31:0] b_t   [9] = '{32'h1, 32'h1, 32'h1, 32'h0FF00F0F, 32'h0FF00F0F,
                               32'h0FF00F0F, 32'h0FF00F0F, 32'h2, 32'hFFFFFFFF};
    logic [31:0] exp_t [9] = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'h00F0000F, 32'hFFF00FFF,
                               32'hFF000FF0, 32'h000FF000, 32'h1, 32'h0};
    int cyc;
    for (int i = 0; i < 9; i++) begin
      set_reg(3'd1, a_t[i]);
      set_reg(3'd2, b_t[i]);
      run_op(op_t[i], 3'd1, 3'd2, 3'd3, cyc);
      total++; if (WRT_DATA !== exp_t[i] || EN !== 1'b1 || cyc !== 3) begin
        bad++; $display("FAIL arith_%0d op %0d: data %h en %b cyc %0d expected %h 1 3", i, op_t[i], WRT_DATA, EN, cyc, exp_t[i]);
      end
      step();
      total++; if (bank[3] !== exp_t[i]) begin bad++; $display("FAIL arith_bank_%0d: R3 %h expected %h", i, bank[3], exp_t[i]); end
    end
  endtask

  task automatic test_shift();
    logic [3:0]  op_t  [7] = '{4'd10, 4'd9, 4'd8, 4'd8, 4'd9, 4'd10, 4'd8};
    logic [31:0] a_t   [7] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h00000011,
                               32'h80000000, 32'h80000000, 32'h00000001};
    logic [31:0] b_t   [7] = '{32'd4, 32'd4, 32'd0, 32'd4, 32'd1, 32'd31, 32'h24};
    logic [31:0] exp_t [7] = '{32'hF8000000, 32'h08000000, 32'h80000000, 32'h00000110,
                               32'h40000000, 32'hFFFFFFFF, 32'h00000010};
    int          cyc_t [7] = '{6, 6, 3, 6, 3, 33, 6};
    int cyc;
    for (int i = 0; i < 7; i++) begin
      set_reg(3'd1, a_t[i]);
      set_reg(3'd2, b_t[i]);
      run_op(op_t[i], 3'd1, 3'd2, 3'd3, cyc);
      total++; if (WRT_DATA !== exp_t[i] || EN !== 1'b1 || cyc !== cyc_t[i]) begin
        bad++; $display("FAIL shift_%0d op %0d: data %h en %b cyc %0d expected %h 1 %0d", i, op_t[i], WRT_DATA, EN, cyc, exp_t[i], cyc_t[i]);
      end
      step();
    end
  endtask

  task automatic test_mul();
    logic [31:0] a_t   [4] = '{32'h00010003, 32'hFFFFFFFF, 32'h12345678, 32'h0000FFFF};
    logic [31:0] b_t   [4] = '{32'h00000010, 32'h00000002, 32'h00000000, 32'h0000FFFF};
    logic [31:0] exp_t [4] = '{32'h00100030, 32'hFFFFFFFE, 32'h00000000, 32'hFFFE0001};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      set_reg(3'd4, a_t[i]);
      set_reg(3'd5, b_t[i]);
      run_op(4'd11, 3'd4, 3'd5, 3'd7, cyc);
      total++; if (WRT_DATA !== exp_t[i] || EN !== 1'b1 || DEST_REG !== 3'd7 || cyc !== 34) begin
        bad++; $display("FAIL mul_%0d: data %h en %b dest %0d cyc %0d expected %h 1 7 34", i, WRT_DATA, EN, DEST_REG, cyc, exp_t[i]);
      end
      step();
      total++; if (bank[7] !== exp_t[i]) begin bad++; $display("FAIL mul_bank_%0d: R7 %h expected %h", i, bank[7], exp_t[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int en0;
    set_reg(3'd1, 32'd100);
    set_reg(3'd2, 32'd1);
    set_reg(3'd5, 32'hAA);
    en0 = en_count;
    issue(4'd0, 3'd1, 3'd2, 3'd3);
    // Start stays high through READ, EXEC and WB with a different destination.
    opcode = 4'd0; src1 = 3'd1; src2 = 3'd1; dest = 3'd5; start = 1'b1;
    wait_done(cyc);
    total++; if (cyc !== 3 || WRT_DATA !== 32'd101) begin
      bad++; $display("FAIL busy_start_op: cyc %0d data %h expected 3 00000065", cyc, WRT_DATA);
    end
    step();
    start = 1'b0;
    repeat (3) step();
    total++; if (en_count - en0 !== 1 || busy !== 1'b0 || bank[5] !== 32'hAA) begin
      bad++; $display("FAIL busy_start_ignored: writes %0d busy %b R5 %h expected 1 0 000000aa", en_count - en0, busy, bank[5]);
    end
    // Two ops back to back: the second start comes in the first idle cycle.
    run_op(4'd0, 3'd1, 3'd2, 3'd3, cyc);
    step();
    run_op(4'd1, 3'd3, 3'd2, 3'd4, cyc);
    total++; if (cyc !== 3 || WRT_DATA !== 32'd100 || DEST_REG !== 3'd4) begin
      bad++; $display("FAIL back_to_back: cyc %0d data %h dest %0d expected 3 00000064 4", cyc, WRT_DATA, DEST_REG);
    end
    step();
  endtask

  task automatic test_hazard();
    int cyc;
    set_reg(3'd6, 32'd9);
    run_op(4'd0, 3'd6, 3'd6, 3'd6, cyc);
    total++; if (WRT_DATA !== 32'd18 || EN !== 1'b1) begin bad++; $display("FAIL hazard_wb: data %h en %b expected 00000012 1", WRT_DATA, EN); end
    step();
    total++; if (bank[6] !== 32'd18) begin bad++; $display("FAIL hazard_bank: R6 %h expected 00000012", bank[6]); end
  endtask

  task automatic test_illegal();
    int cyc;
    int en0;
    set_reg(3'd3, 32'h55);
    en0 = en_count;
    run_op(4'd13, 3'd1, 3'd2, 3'd3, cyc);
    total++; if (illegal !== 1'b1 || done !== 1'b1 || EN !== 1'b0 || cyc !== 3) begin
      bad++; $display("FAIL illegal_wb: ill %b done %b en %b cyc %0d expected 1 1 0 3", illegal, done, EN, cyc);
    end
    step();
    total++; if (illegal !== 1'b0 || bank[3] !== 32'h55 || en_count !== en0) begin
      bad++; $display("FAIL illegal_after: ill %b R3 %h writes %0d expected 0 00000055 0", illegal, bank[3], en_count - en0);
    end
  endtask

  task automatic test_reset_mid_op();
    int en0;
    logic [44:0] obs;
    set_reg(3'd4, 32'h3);
    set_reg(3'd5, 32'h3);
    en0 = en_count;
    issue(4'd11, 3'd4, 3'd5, 3'd2);
    repeat (10) step();
    total++; if (busy !== 1'b1 || dbg_state !== 2'd2) begin bad++; $display("FAIL mid_busy: busy %b state %0d expected 1 2", busy, dbg_state); end
    rst = 1'b0;
    step();
    obs = {SRC_REG1, SRC_REG2, DEST_REG, WRT_DATA, EN, busy, done, illegal};
    total++; if (obs !== '0 || dbg_state !== 2'd0) begin bad++; $display("FAIL mid_reset: got %h state %0d expected 0", obs, dbg_state); end
    rst = 1'b1;
    repeat (40) step();
    total++; if (en_count !== en0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_no_write: writes %0d busy %b done %b expected 0 0 0", en_count - en0, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_shift();
    test_mul();
    test_back_to_back();
    test_hazard();
    test_illegal();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Sequential execute/write-back controller sitting directly in front of the 8 x 32-bit register bank.
- Accepts one operation per start/done handshake and drives the bank's read addresses.
- Captures REG1_DATA/REG2_DATA, computes the result (single-cycle logic/arith ops; iterative shifts and multiply), then drives DEST_REG/WRT_DATA/EN for exactly one write cycle.

Parameters:
- DW, 32, datapath width; must match the register bank data width.
- AW, 3, register address width (8 registers).
- SHW, 5, shift-amount width, taken from operand 2 bits [SHW-1:0].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- start  in  1  request; accepted only when busy=0.
- opcode  in  4  operation select, captured at accept.
- src1  in  AW  operand-1 register index, captured at accept.
- src2  in  AW  operand-2 register index, captured at accept.
- dest  in  AW  destination register index, captured at accept.
- REG1_DATA  in  DW  bank read port 1; combinational from SRC_REG1.
- REG2_DATA  in  DW  bank read port 2; combinational from SRC_REG2.
- SRC_REG1  out  AW  registered read address 1 to the bank.
- SRC_REG2  out  AW  registered read address 2 to the bank.
- DEST_REG  out  AW  registered write address to the bank.
- WRT_DATA  out  DW  registered write data to the bank.
- EN  out  1  bank write enable; high for exactly one cycle per legal op.
- busy  out  1  high from the cycle after accept through the WB cycle.
- done  out  1  one-cycle pulse in the WB cycle.
- illegal  out  1  one-cycle pulse in the WB cycle when the opcode is unsupported.

Behaviour:
- Reset: rst=0 at a rising edge forces
  - state=IDLE;
  - SRC_REG1, SRC_REG2, DEST_REG, WRT_DATA, EN, busy, done and illegal all 0;
  - internal operand, accumulator and counter registers 0.
- Reset mid-operation: the op is abandoned and no write occurs. If rst=0 is sampled at the edge ending WB, EN is 0 the next cycle; the write at that same edge still lands in the bank.
- States: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: when start=1 at an edge:
  - latch opcode and dest;
  - load src1/src2 into SRC_REG1/SRC_REG2;
  - go to READ; busy=1 from the next cycle.
  - start while busy=1 is ignored; start is not queued.
- READ, one cycle: capture REG1_DATA into A and REG2_DATA into B at the edge ending READ.
- Operand sampling: operands are sampled before any write, so dest==src1/src2 reads the old value.
- EXEC, single-cycle ops (1 cycle), opcodes:
  - 0 ADD: A+B, modulo 2^DW.
  - 1 SUB: A-B, modulo 2^DW.
  - 2 AND; 3 OR; 4 XOR; 5 NOR.
  - 6 SLT: signed compare, result 1 or 0.
  - 7 SLTU: unsigned compare, result 1 or 0.
- EXEC, shifts 8 SLL / 9 SRL / 10 SRA:
  - shift amount n = B[SHW-1:0];
  - one bit position per cycle;
  - EXEC lasts max(n,1) cycles; n=0 returns A unchanged.
  - SRA replicates A[DW-1].
- EXEC, 11 MUL:
  - unsigned shift-add, one multiplier bit per cycle, exactly DW cycles;
  - result is the low DW bits of A*B.
- Opcodes 12-15: illegal. EXEC lasts 1 cycle; in WB, EN=0, done=1, illegal=1.
- WB, one cycle:
  - EN=1 (legal ops), DEST_REG=latched dest, WRT_DATA=result;
  - done=1, busy=1.
  - The bank writes at the edge ending WB; the next cycle is IDLE with busy=0 and EN=0.
- Latency, start sampled at edge E0:
  - single-cycle op: READ, EXEC and WB occupy the cycles after E0, E1 and E2; done in the cycle after E2.
  - next start is accepted at E3 earliest.
  - total cycles from accept to done = 3 + (EXEC length - 1).
- Outputs when not in WB: WRT_DATA and DEST_REG hold their last values; EN, done and illegal are 0.
- Width rules:
  - all arithmetic is DW-bit with carries/overflow discarded;
  - a shift amount above DW-1 is impossible given SHW=5 with DW=32.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, release, no start -> all outputs 0 and EN never asserts.
- ADD: bank R1=7, R2=5; start op=0 src1=1 src2=2 dest=3 -> SRC_REG1=1 and SRC_REG2=2 one cycle after accept; EN=1, DEST_REG=3, WRT_DATA=12, done=1 exactly 3 cycles after accept; R3 reads 12 afterwards.
- Arithmetic edge cases:
  - SUB with R1=0, R2=1 -> WRT_DATA=0xFFFFFFFF.
  - SLT with R1=0xFFFFFFFF, R2=1 -> 1.
  - SLTU with the same operands -> 0.
- Shifts with R1=0x80000000:
  - SRA by 4 -> 0xF8000000 after 4 EXEC cycles (done 6 cycles after accept).
  - SRL by 4 -> 0x08000000.
  - SLL by 0 -> 0x80000000 after 1 EXEC cycle.
- MUL: R4=0x0001_0003, R5=0x0000_0010 -> WRT_DATA=0x0010_0030; done exactly 34 cycles after accept.
- Hazards and robustness:
  - start pulsed while busy -> ignored, exactly one write occurs;
  - dest=src1=src2=6 with R6=9 and ADD -> R6=18;
  - opcode 13 -> illegal=1, done=1, EN=0, bank unchanged;
  - rst=0 asserted during MUL EXEC -> no EN pulse and all outputs 0 the next cycle.
